// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int unsigned ITERS   = 32;
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage and the mul/div unit.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);

endinterface

// File: rtl/muldiv_iter.sv
// Unsigned iterative core: shift-add multiply / restoring divide on magnitudes.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITERS = muldiv_pkg::ITERS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   mag_a_i,
  input  logic [WIDTH-1:0]   mag_b_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               last_o
);

  localparam int unsigned CW = $clog2(ITERS);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic               div_q;
  logic [CW-1:0]      cnt_q;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] shifted;

  always_comb begin
    acc_d   = acc_q;
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    shifted = {acc_q[2*WIDTH-2:0], 1'b0};
    // Partial remainder after the shift can reach WIDTH+1 bits; bit WIDTH of diff is the borrow.
    diff    = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    if (div_q) begin
      if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
      else              acc_d = shifted;
    end else begin
      if (acc_q[0]) acc_d = {sum, acc_q[WIDTH-1:1]};
      else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  // The result is the value being registered on the final step, so the wrapper can write HI/LO on that edge.
  assign result_o = acc_d;
  assign last_o   = step_i && (cnt_q == CW'(ITERS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (load_i) begin
      acc_q  <= {{WIDTH{1'b0}}, (is_div_i ? mag_a_i : mag_b_i)};
      opnd_q <= is_div_i ? mag_b_i : mag_a_i;
      div_q  <= is_div_i;
      cnt_q  <= '0;
    end else if (step_i) begin
      acc_q  <= acc_d;
      cnt_q  <= last_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Optional MULDIV_SINGLE_CYCLE_MULT_EN: multiplies complete at the accept edge via '*'.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITERS = muldiv_pkg::ITERS
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               neg_q, rem_neg_q, div_q, div0_q;
  logic [WIDTH-1:0]   a_q;

  logic               is_signed, is_div, a_neg, b_neg, load;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
  logic [2*WIDTH-1:0] raw, prod;
  logic               last;

`ifdef MULDIV_SINGLE_CYCLE_MULT_EN
  logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
  assign ext_a     = {{WIDTH{is_signed & bus.a[WIDTH-1]}}, bus.a};
  assign ext_b     = {{WIDTH{is_signed & bus.b[WIDTH-1]}}, bus.b};
  // Sign-extended operands make the truncated 2W-bit product correct for both signednesses.
  assign fast_prod = ext_a * ext_b;
`endif

  assign is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign is_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign a_neg     = is_signed && bus.a[WIDTH-1];
  assign b_neg     = is_signed && bus.b[WIDTH-1];
  assign mag_a     = a_neg ? -bus.a : bus.a;
  assign mag_b     = b_neg ? -bus.b : bus.b;

  muldiv_iter #(.WIDTH(WIDTH), .ITERS(ITERS)) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load),
    .step_i   (state_q == S_RUN),
    .is_div_i (is_div),
    .mag_a_i  (mag_a),
    .mag_b_i  (mag_b),
    .result_o (raw),
    .last_o   (last)
  );

  assign quo  = neg_q     ? -raw[WIDTH-1:0]       : raw[WIDTH-1:0];
  assign rem  = rem_neg_q ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
  assign prod = neg_q     ? -raw                  : raw;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MTHI: hi_d = bus.a;
            OP_MTLO: lo_d = bus.a;
            OP_MULT, OP_MULTU: begin
`ifdef MULDIV_SINGLE_CYCLE_MULT_EN
              hi_d   = fast_prod[2*WIDTH-1:WIDTH];
              lo_d   = fast_prod[WIDTH-1:0];
              done_d = 1'b1;
`else
              load    = 1'b1;
              state_d = S_RUN;
`endif
            end
            OP_DIV, OP_DIVU: begin
              load    = 1'b1;
              state_d = S_RUN;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (div_q && div0_q) begin
            hi_d = a_q;
            lo_d = DIV0_LO;
          end else if (div_q) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div_q     <= 1'b0;
      div0_q    <= 1'b0;
      a_q       <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      if (load) begin
        neg_q     <= a_neg ^ b_neg;
        rem_neg_q <= a_neg;
        div_q     <= is_div;
        div0_q    <= (bus.b == '0);
        a_q       <= bus.a;
      end
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
